// File: rtl/solve_ctrl_if.sv
// Solver handshake: start pulse out, completion pulse with result back.
interface solve_ctrl_if;
    logic        slv_start;
    logic        slv_done;
    logic        slv_fail;
    logic [4:0]  slv_cnt;
    logic [39:0] slv_ord;

    modport master (
        output slv_start,
        input  slv_done,
        input  slv_fail,
        input  slv_cnt,
        input  slv_ord
    );

    modport slave (
        input  slv_start,
        output slv_done,
        output slv_fail,
        output slv_cnt,
        output slv_ord
    );
endinterface

// File: rtl/solve_ctrl.sv
// 5-puzzle sequencer: button debounce, solver handshake with timeout,
// move-list latch and manual/auto stepping of the move index.
module solve_ctrl #(
    parameter int unsigned TICK_DIV      = 4096,
    parameter int unsigned DEB_TICKS     = 4,
    parameter int unsigned AUTO_TICKS    = 256,
    parameter int unsigned TIMEOUT_TICKS = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          btn,
    solve_ctrl_if.master        slv,
    output logic                busy,
    output logic                comp,
    output logic                err,
    output logic [4:0]          num,
    output logic [1:0]          move,
    output logic                mv_vld
);

    localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = $clog2(DEB_TICKS + 1);
    localparam int unsigned AW = $clog2(AUTO_TICKS + 1);
    localparam int unsigned OW = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [2:0] {StIdle, StSolve, StShow, StAuto, StFail} state_e;

    // ---------------------------------------------------------------- prescaler
    logic [TW-1:0] pre_q;
    logic          tick;

    assign tick = (pre_q == TW'(TICK_DIV - 1));

    // Free-running scan-tick prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= tick ? '0 : pre_q + 1'b1;
    end

    // ---------------------------------------------------------------- debounce
    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    stab_q, stab_d;
    logic [4:0]    ev_q, ev_d;
    logic [DW-1:0] deb_q [5];
    logic [DW-1:0] deb_d [5];

    // Per-button stability counter, advanced only on scan ticks.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            stab_d[i] = stab_q[i];
            deb_d[i]  = deb_q[i];
            if (tick) begin
                if (sync2_q[i] != stab_q[i]) begin
                    if (deb_q[i] == DW'(DEB_TICKS - 1)) begin
                        stab_d[i] = sync2_q[i];
                        deb_d[i]  = '0;
                    end else begin
                        deb_d[i] = deb_q[i] + 1'b1;
                    end
                end else begin
                    deb_d[i] = '0;
                end
            end
        end
        // Press event on a 0->1 flip of the stable level.
        ev_d = stab_d & ~stab_q;
    end

    // Synchronizer, stable levels and registered press events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            stab_q  <= '0;
            ev_q    <= '0;
            for (int i = 0; i < 5; i++) deb_q[i] <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            stab_q  <= stab_d;
            ev_q    <= ev_d;
            for (int i = 0; i < 5; i++) deb_q[i] <= deb_d[i];
        end
    end

    // Only the highest-priority coincident event survives: 0 > 1 > 4 > 3 > 2.
    logic e_clr, e_slv, e_nxt, e_prv, e_aut;

    assign e_clr = ev_q[0];
    assign e_slv = ev_q[1] & ~ev_q[0];
    assign e_nxt = ev_q[4] & ~|ev_q[1:0];
    assign e_prv = ev_q[3] & ~ev_q[4] & ~|ev_q[1:0];
    assign e_aut = ev_q[2] & ~|ev_q[4:3] & ~|ev_q[1:0];

    // ---------------------------------------------------------------- sequencer
    state_e        state_q, state_d;
    logic [4:0]    num_q, num_d;
    logic [4:0]    cnt_q;
    logic [39:0]   ord_q;
    logic [OW-1:0] to_q, to_d;
    logic [AW-1:0] au_q, au_d;
    logic          start_q, start_d;
    logic          load;

    // Index arithmetic widened so cnt_q = 0 cannot underflow.
    logic [5:0] num_inc;
    logic       can_inc, can_dec, can_auto, timeout, astep;

    assign num_inc  = {1'b0, num_q} + 6'd1;
    assign can_inc  = num_inc < {1'b0, cnt_q};
    assign can_dec  = num_q != 5'd0;
    assign can_auto = (cnt_q >= 5'd2) && can_inc;
    assign timeout  = tick && (to_q == OW'(TIMEOUT_TICKS - 1));
    assign astep    = tick && (au_q == AW'(AUTO_TICKS - 1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            num_q   <= '0;
            cnt_q   <= '0;
            ord_q   <= '0;
            to_q    <= '0;
            au_q    <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            to_q    <= to_d;
            au_q    <= au_d;
            start_q <= start_d;
            if (load) begin
                cnt_q <= (slv.slv_cnt > 5'd20) ? 5'd20 : slv.slv_cnt;
                ord_q <= slv.slv_ord;
            end
        end
    end

    // Next-state, index and counter control.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        to_d    = to_q;
        au_d    = au_q;
        start_d = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                num_d = '0;
                if (e_slv) begin
                    start_d = 1'b1;
                    to_d    = '0;
                    state_d = StSolve;
                end
            end
            StSolve: begin
                if (tick) to_d = to_q + 1'b1;
                if (e_clr) begin
                    num_d   = '0;
                    state_d = StIdle;
                end else if (slv.slv_done) begin
                    // Completion beats a same-cycle timeout.
                    if (slv.slv_fail) begin
                        state_d = StFail;
                    end else begin
                        load    = 1'b1;
                        num_d   = '0;
                        state_d = StShow;
                    end
                end else if (timeout) begin
                    state_d = StFail;
                end
            end
            StShow: begin
                if (e_clr) begin
                    num_d   = '0;
                    state_d = StIdle;
                end else if (e_slv) begin
                    start_d = 1'b1;
                    to_d    = '0;
                    state_d = StSolve;
                end else if (e_nxt) begin
                    if (can_inc) num_d = num_q + 1'b1;
                end else if (e_prv) begin
                    if (can_dec) num_d = num_q - 1'b1;
                end else if (e_aut && can_auto) begin
                    au_d    = '0;
                    state_d = StAuto;
                end
            end
            StAuto: begin
                if (e_clr) begin
                    num_d   = '0;
                    state_d = StIdle;
                end else if (e_slv) begin
                    start_d = 1'b1;
                    to_d    = '0;
                    state_d = StSolve;
                end else if (e_nxt) begin
                    if (can_inc) num_d = num_q + 1'b1;
                    state_d = StShow;
                end else if (e_prv) begin
                    if (can_dec) num_d = num_q - 1'b1;
                    state_d = StShow;
                end else if (e_aut) begin
                    state_d = StShow;
                end else begin
                    if (tick) au_d = au_q + 1'b1;
                    if (astep) begin
                        au_d = '0;
                        if (can_inc) num_d = num_q + 1'b1;
                        // Stop once the last move is on display.
                        if (!can_inc || (num_inc + 6'd1 == {1'b0, cnt_q})) state_d = StShow;
                    end
                end
            end
            StFail: begin
                if (e_clr) begin
                    num_d   = '0;
                    state_d = StIdle;
                end else if (e_slv) begin
                    start_d = 1'b1;
                    to_d    = '0;
                    state_d = StSolve;
                end
            end
            default: begin
                num_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registers only.
    logic [39:0] ord_sh;

    always_comb begin
        busy   = (state_q == StSolve);
        comp   = (state_q == StShow) || (state_q == StAuto);
        err    = (state_q == StFail);
        mv_vld = comp && (cnt_q != 5'd0);
        ord_sh = ord_q >> {num_q, 1'b0};
        move   = comp ? ord_sh[1:0] : 2'b00;
    end

    assign num           = num_q;
    assign slv.slv_start = start_q;

endmodule

// File: tb/tb_solve_ctrl.sv
// Directed bench for solve_ctrl with small tick parameters.
module tb_solve_ctrl;

    localparam int unsigned TICK_DIV      = 4;
    localparam int unsigned DEB_TICKS     = 4;
    localparam int unsigned AUTO_TICKS    = 2;
    localparam int unsigned TIMEOUT_TICKS = 40;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn;
    logic       busy, comp, err, mv_vld;
    logic [4:0] num;
    logic [1:0] move;

    solve_ctrl_if sif ();

    solve_ctrl #(
        .TICK_DIV      (TICK_DIV),
        .DEB_TICKS     (DEB_TICKS),
        .AUTO_TICKS    (AUTO_TICKS),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn),
        .slv    (sif),
        .busy   (busy),
        .comp   (comp),
        .err    (err),
        .num    (num),
        .move   (move),
        .mv_vld (mv_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int starts = 0;
    int long_pulses = 0;
    logic prev_start = 1'b0;

    // Count start pulses and flag any lasting more than one clock.
    always @(negedge clk) begin
        if (sif.slv_start === 1'b1) begin
            starts++;
            if (prev_start) long_pulses++;
        end
        prev_start = (sif.slv_start === 1'b1);
    end

    typedef struct {
        logic [4:0] btn;
        logic [4:0] num;
        logic [1:0] move;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] mask);
        btn = mask;
        clks(32);
        btn = '0;
        clks(32);
    endtask

    task automatic done(input logic fail, input logic [4:0] cnt, input logic [39:0] ord);
        sif.slv_done = 1'b1;
        sif.slv_fail = fail;
        sif.slv_cnt  = cnt;
        sif.slv_ord  = ord;
        clks(1);
        sif.slv_done = 1'b0;
        sif.slv_fail = 1'b0;
        clks(1);
    endtask

    task automatic wait_num(input logic [4:0] v, input int limit, output int cyc);
        cyc = 0;
        while (num !== v && cyc < limit) begin
            clks(1);
            cyc++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " slv_start"}, sif.slv_start, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " comp"}, comp, 0);
        check({tag, " err"}, err, 0);
        check({tag, " num"}, num, 0);
        check({tag, " move"}, move, 0);
        check({tag, " mv_vld"}, mv_vld, 0);
    endtask

    initial begin
        int s0;
        int c;
        int lim;

        vecs[0] = '{btn: 5'b10000, num: 5'd1, move: 2'b10};
        vecs[1] = '{btn: 5'b10000, num: 5'd2, move: 2'b11};
        vecs[2] = '{btn: 5'b10000, num: 5'd2, move: 2'b11};
        vecs[3] = '{btn: 5'b01000, num: 5'd1, move: 2'b10};
        vecs[4] = '{btn: 5'b01000, num: 5'd0, move: 2'b01};
        vecs[5] = '{btn: 5'b01000, num: 5'd0, move: 2'b01};

        rst_n        = 1'b0;
        btn          = '0;
        sif.slv_done = 1'b0;
        sif.slv_fail = 1'b0;
        sif.slv_cnt  = '0;
        sif.slv_ord  = '0;
        clks(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        clks(2);

        // Solve and step.
        s0 = starts;
        press(5'b00010);
        check("solve start pulses", starts - s0, 1);
        check("solve busy", busy, 1);
        done(1'b0, 5'd3, 40'h39);
        check("show comp", comp, 1);
        check("show busy", busy, 0);
        check("show num", num, 0);
        check("show move", move, 2'b01);
        check("show mv_vld", mv_vld, 1);
        for (int i = 0; i < 6; i++) begin
            press(vecs[i].btn);
            check($sformatf("step%0d num", i), num, vecs[i].num);
            check($sformatf("step%0d move", i), move, vecs[i].move);
        end

        // Debounce: short glitch ignored, long hold gives one step.
        btn = 5'b10000;
        clks(10);
        btn = '0;
        clks(40);
        check("glitch num", num, 0);
        btn = 5'b10000;
        clks(80);
        btn = '0;
        clks(40);
        check("hold num", num, 1);

        // Auto-play with four moves.
        s0 = starts;
        press(5'b00010);
        check("resolve start pulses", starts - s0, 1);
        check("resolve comp", comp, 0);
        done(1'b0, 5'd4, 40'hE4);
        check("auto pre num", num, 0);
        btn = 5'b00100;
        wait_num(5'd1, 80, c);
        check("auto num1", num, 1);
        wait_num(5'd2, 20, c);
        check("auto num2", num, 2);
        check("auto interval 1-2", c, 8);
        wait_num(5'd3, 20, c);
        check("auto num3", num, 3);
        check("auto interval 2-3", c, 8);
        btn = '0;
        clks(60);
        check("auto end num", num, 3);
        check("auto end move", move, 2'b11);
        check("auto end comp", comp, 1);
        press(5'b10000);
        check("show hold at last", num, 3);

        // Coincident clear and next: clear wins.
        press(5'b10001);
        check("prio comp", comp, 0);
        check("prio num", num, 0);
        check("prio busy", busy, 0);

        // Fail, retry, abort.
        s0 = starts;
        press(5'b00010);
        done(1'b1, 5'd3, 40'h39);
        check("fail err", err, 1);
        check("fail busy", busy, 0);
        press(5'b00010);
        check("retry start pulses", starts - s0, 2);
        check("retry busy", busy, 1);
        check("retry err", err, 0);
        press(5'b00001);
        check("abort busy", busy, 0);
        done(1'b0, 5'd3, 40'h39);
        check("abort late done comp", comp, 0);
        check("abort late done busy", busy, 0);

        // Timeout.
        press(5'b00010);
        check("timeout still busy", busy, 1);
        lim = 0;
        while (err !== 1'b1 && lim < 200) begin
            clks(1);
            lim++;
        end
        check("timeout err", err, 1);
        check("timeout busy", busy, 0);
        press(5'b00001);
        check("timeout clear err", err, 0);
        done(1'b0, 5'd3, 40'h39);
        check("timeout late done comp", comp, 0);

        // Empty move list.
        press(5'b00010);
        done(1'b0, 5'd0, {40{1'b1}});
        check("empty comp", comp, 1);
        check("empty mv_vld", mv_vld, 0);
        check("empty move", move, 2'b11);
        press(5'b10000);
        check("empty next num", num, 0);
        press(5'b00100);
        clks(20);
        check("empty auto num", num, 0);
        check("empty auto comp", comp, 1);

        // Count clamps to 20 moves.
        press(5'b00010);
        done(1'b0, 5'd25, 40'hC0_0000_0000);
        btn = 5'b00100;
        wait_num(5'd19, 250, c);
        btn = '0;
        check("clamp num19", num, 19);
        clks(40);
        check("clamp hold num", num, 19);
        check("clamp move", move, 2'b11);
        check("clamp comp", comp, 1);

        // Asynchronous reset in the middle of auto-play.
        press(5'b00010);
        done(1'b0, 5'd20, 40'h12345_6789A);
        btn = 5'b00100;
        wait_num(5'd1, 80, c);
        check("mid-auto num", num, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        btn = '0;
        clks(2);
        rst_n = 1'b1;
        clks(2);
        check_all_zero("after reset");

        check("start pulse width", long_pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/solve_ctrl.md
# solve_ctrl

Top-level sequencer for the 5-puzzle board. It debounces the five front-panel buttons and starts the solver with a handshake, guarding the solve with a timeout. It latches the returned move list and steps a move index through it, either manually or in timed auto-play. Its `comp`, `num` and `move` outputs feed the 7-segment display path.

## Interface
- `TICK_DIV`, 4096: clocks per scan tick; matches the 7-seg scan rate; ≥2.
- `DEB_TICKS`, 4: consecutive equal tick samples needed to accept a button level change; ≥1.
- `AUTO_TICKS`, 256: ticks between auto-play steps; ≥1.
- `TIMEOUT_TICKS`, 65535: ticks allowed in SOLVE before FAIL; ≥1.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn` in 5: raw buttons, active-high, asynchronous to `clk`.
  - [4] next, [3] prev, [2] auto toggle, [1] solve, [0] clear.
- `slv_done` in 1: solver single-cycle completion pulse.
- `slv_fail` in 1: qualifies `slv_done`; 1 = no solution.
- `slv_cnt` in 5: move count, valid with `slv_done`.
- `slv_ord` in 40: move list, valid with `slv_done`. Move k is `slv_ord[2k+1:2k]`.
- `slv_start` out 1: single-cycle start pulse to the solver.
- `busy` out 1: high in SOLVE.
- `comp` out 1: high in SHOW and AUTO.
- `err` out 1: high in FAIL.
- `num` out 5: current move index.
- `move` out 2: current move code. 00 up, 01 down, 10 left, 11 right.
- `mv_vld` out 1: `comp` and `cnt_q`≠0.

## Operation
- **Tick:** the prescaler counts 0..`TICK_DIV`-1 from reset. `tick` pulses for one clk when the count reaches `TICK_DIV`-1.
- **Input sync:** `btn` passes through a 2-flop synchronizer.
- **Debounce:** each button has a stable level, reset 0, and a sample counter.
  - On a tick, a synchronized level differing from the stable level increments the counter; an equal level clears it.
  - When the counter reaches `DEB_TICKS`, the stable level flips and the counter clears.
  - A 0→1 flip of the stable level produces a one-clk press event `ev[i]`.
- **Event priority:** when events coincide, only the highest-priority one acts. Order: ev0 > ev1 > ev4 > ev3 > ev2. Lower-priority events are dropped.
- **Latched result:** `cnt_q` = min(`slv_cnt`, 20) and `ord_q` = `slv_ord`. Both load only on a `slv_done` accepted in SOLVE.
- **Move output:** `move` = `ord_q[2*num+1 : 2*num]` when `comp`, else 00.
- **FSM states:** IDLE, SOLVE, SHOW, AUTO, FAIL. Reset state is IDLE.
- **IDLE**
  - `num`=0.
  - ev1 → pulse `slv_start`, clear the timeout counter, go to SOLVE.
- **SOLVE**
  - The timeout counter increments on each tick.
  - ev0 → IDLE (abort). A later `slv_done` is ignored.
  - `slv_done` with `slv_fail`=1 → FAIL.
  - `slv_done` with `slv_fail`=0 → latch the result, set `num`=0, go to SHOW.
  - Timeout counter reaches `TIMEOUT_TICKS` → FAIL.
  - If `slv_done` and the timeout occur in the same cycle, `slv_done` wins.
- **SHOW**
  - ev4: `num`++ if `num` < `cnt_q`-1, else hold.
  - ev3: `num`-- if `num` > 0, else hold. No wrap in either direction.
  - ev2: only if `cnt_q` ≥ 2 and `num` < `cnt_q`-1, clear the auto counter and go to AUTO; otherwise ignore.
  - ev1 → re-solve as from IDLE: `slv_start` pulse, go to SOLVE, `comp` drops.
  - ev0 → IDLE.
- **AUTO**
  - The auto counter increments on each tick. On reaching `AUTO_TICKS`, `num`++ and the counter clears.
  - If the increment makes `num` = `cnt_q`-1 → SHOW.
  - ev2 → SHOW with `num` held.
  - ev4/ev3 → SHOW with the step applied as in SHOW.
  - ev1/ev0 behave as in SHOW.
- **FAIL**
  - ev0 → IDLE.
  - ev1 → retry: `slv_start` pulse, go to SOLVE.
- **`cnt_q`=0:** SHOW holds `num`=0 and `mv_vld`=0. ev4, ev3 and ev2 are all ignored.

## Timing
- **Reset:** asynchronous assert clears every flop. Outputs after reset: `slv_start`=0, `busy`=0, `comp`=0, `err`=0, `num`=0, `move`=00, `mv_vld`=0. Release is synchronous to `clk`.
- **Button latency:** a press is seen on `ev` 2 clks after a synchronizer edge, plus `DEB_TICKS` ticks.
- **Registered outputs:** all outputs are registered.
  - `slv_start` rises the clk after the accepting event and lasts exactly 1 clk.
  - `busy`, `comp` and `err` follow the state register in the same cycle.
- **Solver completion:** `slv_done` is sampled on the same edge that leaves SOLVE. `comp`=1 and the latched `move` appear the next cycle.
- **Index changes:** an `num` update is visible 1 clk after its event or auto step.
- **Solver inputs:** `slv_done` and `slv_fail` are synchronous to `clk`. `slv_done` outside SOLVE is ignored.

## Test plan
- **Solve and step:** reset; press btn1. Solver returns done with cnt=3, ord=…_11_10_01 (move0=01).
  - Expect one `slv_start` pulse, then `comp`=1, `num`=0, `move`=01.
  - btn4 ×3 → `num`=1 (`move`=10), then 2 (`move`=11), then holds 2.
  - btn3 ×3 → `num`=1, then 0, then holds 0.
- **Auto-play:** `TICK_DIV`=4, `AUTO_TICKS`=2, cnt=4, `num`=0; press btn2.
  - `num` steps every 8 clks to 3, then state returns to SHOW with `num` held at 3.
- **Debounce:** `DEB_TICKS`=4.
  - A btn4 glitch lasting 3 ticks → no change.
  - Holding btn4 for 20 ticks → exactly one increment.
- **Timeout and recovery:** press btn1; no `slv_done` for `TIMEOUT_TICKS` ticks → `err`=1, `busy`=0.
  - btn0 → IDLE.
  - A late `slv_done` → ignored, `comp` stays 0.
- **Fail and abort:** `slv_done` with `slv_fail`=1 → FAIL.
  - btn1 → second `slv_start` pulse.
  - btn0 in SOLVE → IDLE; a subsequent `slv_done` has no effect.
- **Priority and reset:** in SHOW, btn0 and btn4 press events coincide → IDLE, `num`=0. `rst_n` low mid-AUTO → all outputs 0 immediately, without waiting for a clock edge.
